chess_cursor: RTL and testbench
===============================

CHESS_CURSOR -- requirements
Module: chess_cursor

Interface
REQ-001 SHALL have port Clk, input, 1, system clock; all state on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port frame_clk, input, 1, per-frame strobe (vsync-derived), asynchronous to Clk.
REQ-004 SHALL have port keycode, input, 8, USB HID keycode; 0x00 = no key.
REQ-005 SHALL have ports BallX and BallY, output, 10 each, cursor centre pixel, fed to the crosshair color mapper.
REQ-006 SHALL have port Ball_size, output, 10, crosshair half-length, constant 12.
REQ-007 SHALL have ports cur_col and cur_row, output, 3 each, cursor square; col 0 = left, row 0 = top.
REQ-008 SHALL have port sel_active, output, 1, high while a source square is held.
REQ-009 SHALL have ports from_col, from_row, to_col and to_row, output, 3 each, move squares.
REQ-010 SHALL have port move_valid, output, 1, one-Clk pulse when a move is committed.

Function
REQ-011 SHALL use fixed board geometry: X offset 80, Y offset 0, square 60 px.
REQ-012 SHALL compute BallX = 80 + 60*cur_col + 30 and BallY = 60*cur_row + 30, registered and updated on the same edge as cur_col/cur_row.
REQ-013 SHALL synchronise frame_clk through registers s1->s2->s3 and assert tick = s2 & ~s3.
REQ-014 SHALL apply tick actions on the Clk edge ending the tick cycle, i.e. 2 edges after the first edge sampling frame_clk high; exactly one tick per frame_clk rise.
REQ-015 SHALL register prev_key <= keycode on every tick; a key counts as pressed only when keycode != prev_key at the tick (no auto-repeat).
REQ-016 SHALL map pressed keys: 0x1A (W) row-1, 0x16 (S) row+1, 0x04 (A) col-1, 0x07 (D) col+1, 0x2C (space) select, 0x29 (Esc) cancel; all other codes are ignored.
REQ-017 SHALL saturate moves at board edges by default: row-1 at row 0 holds 0, col+1 at col 7 holds 7.
REQ-018 SHALL implement FSM states IDLE and HELD.
REQ-019 IDLE + space SHALL latch from_col/from_row <= cur_col/cur_row, set sel_active=1, and go to HELD.
REQ-020 HELD + space on the from square SHALL cancel: sel_active=0, go to IDLE, no move_valid.
REQ-021 HELD + space on another square SHALL latch to_col/to_row, pulse move_valid for exactly one Clk, clear sel_active, and go to IDLE.
REQ-022 HELD + Esc SHALL go to IDLE with sel_active=0; IDLE + Esc SHALL do nothing.
REQ-023 Cursor movement SHALL be allowed in both states; from_* SHALL stay stable while in HELD.
REQ-024 SHALL not validate chess legality; move_valid only reports a from/to pair.
REQ-025 SHALL hold move_valid at 0 in every cycle without a commit.

Reset
REQ-026 SHALL, while Reset is high, set cur_col=4, cur_row=6, BallX=350, BallY=390, state IDLE, sel_active=0, move_valid=0, from_*/to_*=0, prev_key=0x00, s1/s2/s3=0.
REQ-027 Reset asserted mid-HELD SHALL discard the selection with no move_valid, and Reset SHALL take priority over a simultaneous tick.
REQ-028 The first tick after reset SHALL treat any held non-zero keycode as a fresh press.

Configuration
REQ-029 SHALL support macro CHESS_CURSOR_WRAP_EN: when defined, edge moves wrap (col 7 + D -> 0, row 0 + W -> 7); when undefined, moves saturate per REQ-017.

Verification
REQ-030 Reset, then 3 frame ticks with keycode 0x00 -> cur_col=4, cur_row=6, BallX=350, BallY=390, move_valid never high.
REQ-031 keycode 0x07 held across 5 ticks -> cur_col=5 after the first tick only; BallX=410, unchanged afterwards.
REQ-032 From col 7, press 0x07 -> col stays 7 without the macro; with CHESS_CURSOR_WRAP_EN col=0 and BallX=110.
REQ-033 Space at (4,6), release, W twice, space -> move_valid high exactly one Clk with from=(4,6), to=(4,4), sel_active=0.
REQ-034 Space, release, space at the same square -> sel_active toggles 1 then 0, and move_valid stays 0.
REQ-035 Space, then Reset pulse mid-HELD -> sel_active=0, state IDLE, and a subsequent space starts a new selection.

Source files
------------

// File: rtl/chess_cursor.sv
// chess_cursor: keyboard-driven chessboard cursor with two-click move selection
// Ports: Clk/Reset (sync, active-high), frame_clk (async per-frame strobe), keycode (USB HID),
//        BallX/BallY/Ball_size (crosshair), cur_col/cur_row (cursor square), sel_active,
//        from_*/to_* (move squares), move_valid (one-Clk commit pulse).
// Option: define CHESS_CURSOR_WRAP_EN to wrap cursor moves at board edges instead of saturating.
module chess_cursor (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic [2:0] cur_col,
    output logic [2:0] cur_row,
    output logic       sel_active,
    output logic [2:0] from_col,
    output logic [2:0] from_row,
    output logic [2:0] to_col,
    output logic [2:0] to_row,
    output logic       move_valid
);
    typedef enum logic {IDLE, HELD} state_t;
    state_t     r_state, w_state_n;
    logic       r_s1, r_s2, r_s3, r_mv;
    logic [7:0] r_prev_key;
    logic [2:0] r_col, r_row, r_from_col, r_from_row, r_to_col, r_to_row;
    logic [2:0] w_col_n, w_row_n, w_from_col, w_from_row, w_to_col, w_to_row;
    logic [9:0] r_bx, r_by;
    logic       w_tick, w_press, w_up, w_dn, w_lf, w_rt, w_sp, w_esc, w_commit;
    assign w_tick  = r_s2 & ~r_s3;
    // a key acts once per change of keycode, sampled only at frame ticks
    assign w_press = w_tick && (keycode != r_prev_key);
    assign w_up    = w_press && keycode == 8'h1A;
    assign w_dn    = w_press && keycode == 8'h16;
    assign w_lf    = w_press && keycode == 8'h04;
    assign w_rt    = w_press && keycode == 8'h07;
    assign w_sp    = w_press && keycode == 8'h2C;
    assign w_esc   = w_press && keycode == 8'h29;
`ifdef CHESS_CURSOR_WRAP_EN
    assign w_row_n = w_up ? r_row - 3'd1 : w_dn ? r_row + 3'd1 : r_row;
    assign w_col_n = w_lf ? r_col - 3'd1 : w_rt ? r_col + 3'd1 : r_col;
`else
    assign w_row_n = (w_up && r_row != 3'd0) ? r_row - 3'd1 : (w_dn && r_row != 3'd7) ? r_row + 3'd1 : r_row;
    assign w_col_n = (w_lf && r_col != 3'd0) ? r_col - 3'd1 : (w_rt && r_col != 3'd7) ? r_col + 3'd1 : r_col;
`endif
    always_comb begin
        w_state_n  = r_state;
        w_from_col = r_from_col;
        w_from_row = r_from_row;
        w_to_col   = r_to_col;
        w_to_row   = r_to_row;
        w_commit   = 1'b0;
        if (r_state == IDLE) begin
            if (w_sp) begin
                w_from_col = r_col;
                w_from_row = r_row;
                w_state_n  = HELD;
            end
        end else if (w_esc) begin
            w_state_n = IDLE;
        end else if (w_sp) begin
            w_state_n = IDLE;
            // second click on the source square is a cancel, not a null move
            if (r_col != r_from_col || r_row != r_from_row) begin
                w_to_col = r_col;
                w_to_row = r_row;
                w_commit = 1'b1;
            end
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_prev_key <= 8'h00;
            r_col      <= 3'd4;
            r_row      <= 3'd6;
            r_bx       <= 10'd350;
            r_by       <= 10'd390;
            r_state    <= IDLE;
            r_from_col <= 3'd0;
            r_from_row <= 3'd0;
            r_to_col   <= 3'd0;
            r_to_row   <= 3'd0;
            r_mv       <= 1'b0;
        end else begin
            r_s1       <= frame_clk;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_prev_key <= w_tick ? keycode : r_prev_key;
            r_col      <= w_col_n;
            r_row      <= w_row_n;
            // square centre: board X offset 80 plus half a 60 px square
            r_bx       <= 10'd110 + 10'd60 * {7'd0, w_col_n};
            r_by       <= 10'd30 + 10'd60 * {7'd0, w_row_n};
            r_state    <= w_state_n;
            r_from_col <= w_from_col;
            r_from_row <= w_from_row;
            r_to_col   <= w_to_col;
            r_to_row   <= w_to_row;
            r_mv       <= w_commit;
        end
    end
    assign BallX      = r_bx;
    assign BallY      = r_by;
    assign Ball_size  = 10'd12;
    assign cur_col    = r_col;
    assign cur_row    = r_row;
    assign sel_active = (r_state == HELD);
    assign from_col   = r_from_col;
    assign from_row   = r_from_row;
    assign to_col     = r_to_col;
    assign to_row     = r_to_row;
    assign move_valid = r_mv;
endmodule

// File: tb/tb_chess_cursor.sv
// tb_chess_cursor: directed scoreboard bench for chess_cursor
module tb_chess_cursor;
    logic       Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] BallX, BallY, Ball_size;
    logic [2:0] cur_col, cur_row, from_col, from_row, to_col, to_row;
    logic       sel_active, move_valid;
    int         total = 0, bad = 0, mv_cnt = 0;
    logic [2:0] cap_fc, cap_fr, cap_tc, cap_tr;
    logic       cap_sel;
    typedef struct {
        string tag;
        int    col;
        int    row;
        int    sel;
        int    mvc;
    } exp_t;
    exp_t sb[$];
    chess_cursor dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
        .cur_col(cur_col), .cur_row(cur_row), .sel_active(sel_active),
        .from_col(from_col), .from_row(from_row), .to_col(to_col), .to_row(to_row),
        .move_valid(move_valid)
    );
    always #5 Clk = ~Clk;
    // every high cycle of move_valid is counted, so a stretched pulse shows up as an extra count
    always @(negedge Clk) begin
        if (move_valid === 1'b1) begin
            mv_cnt  <= mv_cnt + 1;
            cap_fc  <= from_col;
            cap_fr  <= from_row;
            cap_tc  <= to_col;
            cap_tr  <= to_row;
            cap_sel <= sel_active;
        end
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic compare_state(input exp_t e);
        check({e.tag, ".col"}, 32'(cur_col), 32'(e.col));
        check({e.tag, ".row"}, 32'(cur_row), 32'(e.row));
        check({e.tag, ".BallX"}, 32'(BallX), 32'(110 + 60 * e.col));
        check({e.tag, ".BallY"}, 32'(BallY), 32'(30 + 60 * e.row));
        check({e.tag, ".sel"}, 32'(sel_active), 32'(e.sel));
        check({e.tag, ".mvcnt"}, 32'(mv_cnt), 32'(e.mvc));
    endtask
    task automatic frame(input logic [7:0] k, input int ec, input int er, input int es, input int em, input string tag);
        exp_t e;
        e = '{tag, ec, er, es, em};
        sb.push_back(e);
        @(negedge Clk);
        keycode   = k;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        e = sb.pop_front();
        compare_state(e);
    endtask
    task automatic do_reset(input int mvc);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        compare_state('{"rst", 4, 6, 0, mvc});
        check("rst.mv", 32'(move_valid), 32'd0);
        check("rst.from", 32'({from_col, from_row}), 32'd0);
        check("rst.to", 32'({to_col, to_row}), 32'd0);
        check("rst.size", 32'(Ball_size), 32'd12);
        Reset = 1'b0;
        keycode = 8'h00;
    endtask
    initial begin
        do_reset(0);
        for (int i = 0; i < 3; i++) frame(8'h00, 4, 6, 0, 0, "idle");
        for (int i = 0; i < 5; i++) frame(8'h07, 5, 6, 0, 0, "hold_d");
        frame(8'h00, 5, 6, 0, 0, "rel");
        frame(8'h07, 6, 6, 0, 0, "d6");
        frame(8'h00, 6, 6, 0, 0, "rel");
        frame(8'h07, 7, 6, 0, 0, "d7");
        frame(8'h00, 7, 6, 0, 0, "rel");
`ifdef CHESS_CURSOR_WRAP_EN
        frame(8'h07, 0, 6, 0, 0, "d_edge");
`else
        frame(8'h07, 7, 6, 0, 0, "d_edge");
`endif
        frame(8'h55, 7 * 0 + 32'(cur_col), 6, 0, 0, "other_key");
        do_reset(0);
        for (int i = 5; i >= 0; i--) begin
            frame(8'h1A, 4, i, 0, 0, "w");
            frame(8'h00, 4, i, 0, 0, "rel");
        end
`ifdef CHESS_CURSOR_WRAP_EN
        frame(8'h1A, 4, 7, 0, 0, "w_edge");
`else
        frame(8'h1A, 4, 0, 0, 0, "w_edge");
`endif
        do_reset(0);
        frame(8'h2C, 4, 6, 1, 0, "sel");
        frame(8'h00, 4, 6, 1, 0, "rel");
        frame(8'h1A, 4, 5, 1, 0, "w1");
        frame(8'h00, 4, 5, 1, 0, "rel");
        frame(8'h1A, 4, 4, 1, 0, "w2");
        check("held.from", 32'({from_col, from_row}), 32'({3'd4, 3'd6}));
        frame(8'h00, 4, 4, 1, 0, "rel");
        frame(8'h2C, 4, 4, 0, 1, "commit");
        check("commit.from", 32'({cap_fc, cap_fr}), 32'({3'd4, 3'd6}));
        check("commit.to", 32'({cap_tc, cap_tr}), 32'({3'd4, 3'd4}));
        check("commit.sel", 32'(cap_sel), 32'd0);
        frame(8'h00, 4, 4, 0, 1, "rel");
        frame(8'h2C, 4, 4, 1, 1, "sel_same");
        frame(8'h00, 4, 4, 1, 1, "rel");
        frame(8'h2C, 4, 4, 0, 1, "cancel_same");
        frame(8'h00, 4, 4, 0, 1, "rel");
        frame(8'h29, 4, 4, 0, 1, "esc_idle");
        frame(8'h00, 4, 4, 0, 1, "rel");
        frame(8'h2C, 4, 4, 1, 1, "sel_esc");
        frame(8'h29, 4, 4, 0, 1, "esc_held");
        frame(8'h00, 4, 4, 0, 1, "rel");
        frame(8'h2C, 4, 4, 1, 1, "sel_pre_rst");
        // reset lands on top of a frame strobe carrying a fresh space press
        @(negedge Clk);
        keycode   = 8'h00;
        Reset     = 1'b1;
        frame_clk = 1'b1;
        @(negedge Clk);
        keycode   = 8'h2C;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        compare_state('{"mid_rst", 4, 6, 0, 1});
        check("mid_rst.from", 32'({from_col, from_row}), 32'd0);
        frame(8'h2C, 4, 6, 1, 1, "fresh_sel");
        frame(8'h00, 4, 6, 1, 1, "rel");
        frame(8'h07, 5, 6, 1, 1, "d_held");
        frame(8'h00, 5, 6, 1, 1, "rel");
        frame(8'h2C, 5, 6, 0, 2, "commit2");
        check("commit2.from", 32'({cap_fc, cap_fr}), 32'({3'd4, 3'd6}));
        check("commit2.to", 32'({cap_tc, cap_tr}), 32'({3'd5, 3'd6}));
        repeat (4) @(negedge Clk);
        check("final.mvcnt", 32'(mv_cnt), 32'd2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
